// File: rtl/line_buffer_window.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer_window
// Purpose  : Raster-scan 3x3 sliding-window generator for 8-bit grayscale
//            video. Two line buffers supply the two previous rows at the
//            current column. A small shift array holds the two older window
//            columns. A window is emitted one cycle after each accepted pixel
//            whose window lies fully inside the frame.
// Ports    : clk, rst (sync, active-high)
//            in_valid, in_sof, in_pixel[7:0]   - pixel stream, no backpressure
//            out_valid                         - window valid this cycle
//            input_pixel_1..9[7:0]             - window, raster order, 5=centre
//            frame_done                        - pulse with last frame window
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer_window #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_pixel,
  output logic       out_valid,
  output logic [7:0] input_pixel_1,
  output logic [7:0] input_pixel_2,
  output logic [7:0] input_pixel_3,
  output logic [7:0] input_pixel_4,
  output logic [7:0] input_pixel_5,
  output logic [7:0] input_pixel_6,
  output logic [7:0] input_pixel_7,
  output logic [7:0] input_pixel_8,
  output logic [7:0] input_pixel_9,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] c_last_col = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] c_last_row = RW'(IMG_HEIGHT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;

  logic [CW-1:0] w_pos_col;
  logic [RW-1:0] w_pos_row;
  logic [CW-1:0] w_nxt_col;
  logic [RW-1:0] w_nxt_row;
  logic          w_last_col;
  logic          w_last_row;
  logic          w_window;

  // Line buffers: r_lb1 holds row r-1, r_lb2 holds row r-2. Not reset.
  logic [7:0] r_lb1 [IMG_WIDTH];
  logic [7:0] r_lb2 [IMG_WIDTH];
  logic [7:0] w_lb1_rd;
  logic [7:0] w_lb2_rd;

  // Two older columns of the window (index 0 = column c-2, 1 = column c-1).
  // The newest column (lb2, lb1, in_pixel) arrives combinationally, so the
  // full 3x3 window materialises in the output registers.
  logic [7:0] r_top [2];
  logic [7:0] r_mid [2];
  logic [7:0] r_bot [2];

  always_comb begin
    // in_sof relocates the accepted pixel to (0,0) regardless of counters.
    w_pos_col   = in_sof ? '0 : r_col;
    w_pos_row   = in_sof ? '0 : r_row;
    w_last_col  = (w_pos_col == c_last_col);
    w_last_row  = (w_pos_row == c_last_row);
    w_nxt_col   = w_last_col ? '0 : w_pos_col + CW'(1);
    w_nxt_row   = w_pos_row;
    if (w_last_col) begin
      w_nxt_row = w_last_row ? '0 : w_pos_row + RW'(1);
    end
    w_lb1_rd    = r_lb1[w_pos_col];
    w_lb2_rd    = r_lb2[w_pos_col];
    // Row >= 2 implies STREAM; the state term keeps emission confined to it.
    w_window    = in_valid && (r_state == S_STREAM) &&
                  (w_pos_row >= RW'(2)) && (w_pos_col >= CW'(2));
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_state_nxt = S_FILL;
      S_FILL:   if (in_valid && (w_pos_row == RW'(2)) && (w_pos_col == '0))
                  w_state_nxt = S_STREAM;
      S_STREAM: if (in_valid && (in_sof || (w_last_col && w_last_row)))
                  w_state_nxt = S_FILL;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Read-before-write: the old row r-1 value moves down into the r-2 buffer.
  always_ff @(posedge clk) begin
    if (in_valid && !rst) begin
      r_lb1[w_pos_col] <= in_pixel;
      r_lb2[w_pos_col] <= w_lb1_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col         <= '0;
      r_row         <= '0;
      r_state       <= S_IDLE;
      out_valid     <= 1'b0;
      frame_done    <= 1'b0;
      r_top         <= '{default: 8'h00};
      r_mid         <= '{default: 8'h00};
      r_bot         <= '{default: 8'h00};
      input_pixel_1 <= 8'h00;
      input_pixel_2 <= 8'h00;
      input_pixel_3 <= 8'h00;
      input_pixel_4 <= 8'h00;
      input_pixel_5 <= 8'h00;
      input_pixel_6 <= 8'h00;
      input_pixel_7 <= 8'h00;
      input_pixel_8 <= 8'h00;
      input_pixel_9 <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      out_valid  <= w_window;
      frame_done <= w_window && w_last_col && w_last_row;
      if (in_valid) begin
        r_col    <= w_nxt_col;
        r_row    <= w_nxt_row;
        r_top[0] <= r_top[1];
        r_top[1] <= w_lb2_rd;
        r_mid[0] <= r_mid[1];
        r_mid[1] <= w_lb1_rd;
        r_bot[0] <= r_bot[1];
        r_bot[1] <= in_pixel;
      end
      if (w_window) begin
        input_pixel_1 <= r_top[0];
        input_pixel_2 <= r_top[1];
        input_pixel_3 <= w_lb2_rd;
        input_pixel_4 <= r_mid[0];
        input_pixel_5 <= r_mid[1];
        input_pixel_6 <= w_lb1_rd;
        input_pixel_7 <= r_bot[0];
        input_pixel_8 <= r_bot[1];
        input_pixel_9 <= in_pixel;
      end
    end
  end

endmodule
`default_nettype wire
